// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and constants for the USB TX line path
package usb_tx_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_ACTIVE, TX_STUFF_EOP} tx_stuff_state_t;

    localparam int   USB_DEFAULT_MAX_RUN = 6;
    localparam logic USB_J_LEVEL         = 1'b1;

endpackage

// File: rtl/usb_nrzi_enc.sv
// rtl/usb_nrzi_enc.sv - NRZI line-level register: 0 toggles, 1 holds, back to idle after eop
module usb_nrzi_enc
    import usb_tx_pkg::*;
#(
    parameter logic IDLE_LEVEL = USB_J_LEVEL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic emit,
    input  logic bit_in,
    input  logic eop,
    output logic level
);

    logic level_q, level_d;
    logic reload_q, reload_d;
    logic base;

    // The reload applies one cycle after the eop bit is on the line; a bit emitted
    // on that same edge already starts from the idle level.
    always_comb begin
        base     = reload_q ? IDLE_LEVEL : level_q;
        level_d  = base;
        reload_d = 1'b0;
        if (emit) begin
            level_d  = bit_in ? base : ~base;
            reload_d = eop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q  <= IDLE_LEVEL;
            reload_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            reload_q <= reload_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/usb_tx_bit_stuff_nrzi.sv
// rtl/usb_tx_bit_stuff_nrzi.sv - TX bit stuffer with optional NRZI encoding and packet framing
module usb_tx_bit_stuff_nrzi
    import usb_tx_pkg::*;
#(
    parameter int   MAX_RUN    = USB_DEFAULT_MAX_RUN,
    parameter bit   NRZI_EN    = 1'b1,
    parameter logic IDLE_LEVEL = USB_J_LEVEL
) (
    input  logic clk12,
    input  logic RST_N,
    input  logic bitEn,
    input  logic inValid,
    input  logic inData,
    input  logic inLast,
    output logic inReady,
    output logic outValid,
    output logic outData,
    output logic outEop,
    output logic underrun
);

    localparam int            CW         = $clog2(MAX_RUN + 1);
    localparam logic [CW-1:0] RUN_MAX    = CW'(MAX_RUN);
    localparam logic          LINE_RESET = NRZI_EN ? IDLE_LEVEL : 1'b0;

    tx_stuff_state_t state_q, state_d;
    logic [CW-1:0]   run_q, run_d;
    logic [CW-1:0]   run_base, run_new;
    logic            under_q, under_d;
    logic            valid_q, valid_d;
    logic            eop_q, eop_d;
    logic            line_bit;

    assign inReady = (run_q != RUN_MAX) && (state_q != TX_STUFF_EOP);

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        under_d  = under_q;
        valid_d  = 1'b0;
        eop_d    = 1'b0;
        line_bit = 1'b0;
        // A packet's first bit always counts from an empty run.
        run_base = (state_q == TX_IDLE) ? '0 : run_q;
        run_new  = inData ? run_base + CW'(1) : '0;
        if (bitEn) begin
            if (state_q == TX_STUFF_EOP || (state_q == TX_ACTIVE && run_q == RUN_MAX)) begin
                valid_d = 1'b1;
                run_d   = '0;
                if (state_q == TX_STUFF_EOP) begin
                    eop_d   = 1'b1;
                    state_d = TX_IDLE;
                end
            end else if (inValid) begin
                valid_d  = 1'b1;
                line_bit = inData;
                if (state_q == TX_IDLE) begin
                    under_d = 1'b0;
                end
                if (inLast && run_new != RUN_MAX) begin
                    eop_d   = 1'b1;
                    run_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    run_d   = run_new;
                    state_d = inLast ? TX_STUFF_EOP : TX_ACTIVE;
                end
            end else if (state_q == TX_ACTIVE) begin
                // Stall keeps the run count: the line still sees those ones back to back.
                under_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk12 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= TX_IDLE;
            run_q   <= '0;
            under_q <= 1'b0;
            valid_q <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            under_q <= under_d;
            valid_q <= valid_d;
            eop_q   <= eop_d;
        end
    end

    assign outValid = valid_q;
    assign outEop   = eop_q;
    assign underrun = under_q;

    generate
        if (NRZI_EN) begin : g_nrzi
            usb_nrzi_enc #(
                .IDLE_LEVEL (LINE_RESET)
            ) u_nrzi (
                .clk    (clk12),
                .rst_n  (RST_N),
                .emit   (valid_d),
                .bit_in (line_bit),
                .eop    (eop_d),
                .level  (outData)
            );
        end else begin : g_raw
            logic raw_q, raw_d;
            always_comb raw_d = valid_d ? line_bit : raw_q;
            always_ff @(posedge clk12 or negedge RST_N) begin
                if (!RST_N) begin
                    raw_q <= LINE_RESET;
                end else begin
                    raw_q <= raw_d;
                end
            end
            assign outData = raw_q;
        end
    endgenerate

endmodule

// File: tb/tb_usb_tx_bit_stuff_nrzi.sv
// tb/tb_usb_tx_bit_stuff_nrzi.sv - randomized self-checking bench for usb_tx_bit_stuff_nrzi
`timescale 1ns/1ps
module tb_usb_tx_bit_stuff_nrzi;

    logic clk12 = 1'b0;
    logic rst_n = 1'b0;
    logic bit_en = 1'b0, in_valid = 1'b0, in_data = 1'b0, in_last = 1'b0;
    int   sel = 0;
    wire  [2:0] rdy, ov, od, oe, ur;
    logic [2:0] v_sel;

    int n_checks = 0;
    int n_fail   = 0;

    bit pkt[$];
    bit obs_d[$];
    bit obs_e[$];
    int idx = 0;
    int run_m = 0;
    bit pending = 1'b0;
    bit exp_valid = 1'b0;
    bit under_m[3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk12 = ~clk12;

    always_comb begin
        v_sel[0] = in_valid && (sel == 0);
        v_sel[1] = in_valid && (sel == 1);
        v_sel[2] = in_valid && (sel == 2);
    end

    usb_tx_bit_stuff_nrzi #(.MAX_RUN(6), .NRZI_EN(1'b1), .IDLE_LEVEL(1'b1)) dut0 (
        .clk12(clk12), .RST_N(rst_n), .bitEn(bit_en), .inValid(v_sel[0]), .inData(in_data),
        .inLast(in_last), .inReady(rdy[0]), .outValid(ov[0]), .outData(od[0]), .outEop(oe[0]),
        .underrun(ur[0]));

    usb_tx_bit_stuff_nrzi #(.MAX_RUN(6), .NRZI_EN(1'b0), .IDLE_LEVEL(1'b1)) dut1 (
        .clk12(clk12), .RST_N(rst_n), .bitEn(bit_en), .inValid(v_sel[1]), .inData(in_data),
        .inLast(in_last), .inReady(rdy[1]), .outValid(ov[1]), .outData(od[1]), .outEop(oe[1]),
        .underrun(ur[1]));

    usb_tx_bit_stuff_nrzi #(.MAX_RUN(3), .NRZI_EN(1'b1), .IDLE_LEVEL(1'b1)) dut2 (
        .clk12(clk12), .RST_N(rst_n), .bitEn(bit_en), .inValid(v_sel[2]), .inData(in_data),
        .inLast(in_last), .inReady(rdy[2]), .outValid(ov[2]), .outData(od[2]), .outEop(oe[2]),
        .underrun(ur[2]));

    function automatic int max_run_of(input int s);
        return (s == 2) ? 3 : 6;
    endfunction

    function automatic bit nrzi_of(input int s);
        return s != 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d t=%0t got=%0h exp=%0h", tag, sel, $time, got, exp);
        end
    endtask

    // One bit-clock cycle: drive at posedge+1, check at negedge, advance the model.
    task automatic step(input bit ben, input bit val, input bit dat, input bit lst);
        bit cons;
        bit_en = ben; in_valid = val; in_data = dat; in_last = lst;
        @(negedge clk12);
        check_eq("out_valid", 32'(ov[sel]), 32'(exp_valid));
        check_eq("underrun", 32'(ur[sel]), 32'(under_m[sel]));
        check_eq("in_ready", 32'(rdy[sel]), 32'(!pending));
        if (ov[sel] === 1'b1) begin
            obs_d.push_back(od[sel]);
            obs_e.push_back(oe[sel]);
        end else begin
            check_eq("eop_without_valid", 32'(oe[sel]), 32'(0));
        end
        exp_valid = 1'b0;
        cons = 1'b0;
        if (ben) begin
            if (pending) begin
                exp_valid = 1'b1;
                pending = 1'b0;
                run_m = 0;
            end else if (val) begin
                exp_valid = 1'b1;
                cons = 1'b1;
                if (idx == 0) begin
                    under_m[sel] = 1'b0;
                    run_m = 0;
                end
                run_m = dat ? run_m + 1 : 0;
                if (run_m == max_run_of(sel)) pending = 1'b1;
            end else if (idx > 0 && idx < pkt.size()) begin
                under_m[sel] = 1'b1;
            end
        end
        if (cons) idx++;
        @(posedge clk12);
        #1;
    endtask

    task automatic compare_stream();
        bit exp_b[$];
        int ones;
        bit lvl;
        bit line;
        ones = 0;
        lvl = 1'b1;
        foreach (pkt[i]) begin
            exp_b.push_back(pkt[i]);
            ones = pkt[i] ? ones + 1 : 0;
            if (ones == max_run_of(sel)) begin
                exp_b.push_back(1'b0);
                ones = 0;
            end
        end
        check_eq("line_len", 32'(obs_d.size()), 32'(exp_b.size()));
        foreach (exp_b[i]) begin
            if (!exp_b[i]) lvl = ~lvl;
            line = nrzi_of(sel) ? lvl : exp_b[i];
            if (i < obs_d.size()) begin
                check_eq("line_bit", 32'(obs_d[i]), 32'(line));
                check_eq("line_eop", 32'(obs_e[i]), 32'(i == exp_b.size() - 1));
            end
        end
        if (nrzi_of(sel)) check_eq("nrzi_back_to_j", 32'(od[sel]), 32'(1));
    endtask

    task automatic run_packet(input int stall_pct, input int idle_pct, input int stall_at,
                              input int stall_len);
        int guard;
        int stalled;
        bit ben;
        bit val;
        guard = 0;
        stalled = 0;
        idx = 0;
        obs_d.delete();
        obs_e.delete();
        while ((idx < pkt.size() || pending) && guard < 2000) begin
            ben = ($urandom_range(99) >= idle_pct);
            val = (idx < pkt.size());
            if (val && stall_pct > 0 && $urandom_range(99) < stall_pct) val = 1'b0;
            if (val && idx == stall_at && stalled < stall_len) begin
                val = 1'b0;
                if (ben) stalled++;
            end
            step(ben, val, val ? pkt[idx] : 1'b0, val && (idx == pkt.size() - 1));
            guard++;
        end
        check_eq("packet_done_in_time", 32'(guard < 2000), 32'(1));
        repeat (3) step($urandom_range(1), 1'b0, 1'b0, 1'b0);
        compare_stream();
        pkt.delete();
        idx = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk12);
        #1 rst_n = 1'b1;
        @(negedge clk12);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            check_eq("rst_out_valid", 32'(ov[s]), 32'(0));
            check_eq("rst_out_data", 32'(od[s]), 32'(nrzi_of(s) ? 1 : 0));
            check_eq("rst_out_eop", 32'(oe[s]), 32'(0));
            check_eq("rst_underrun", 32'(ur[s]), 32'(0));
            check_eq("rst_in_ready", 32'(rdy[s]), 32'(1));
        end
        @(posedge clk12);
        #1;

        sel = 1; pkt = '{0, 1, 1, 1, 1, 1, 1, 0};    run_packet(0, 0, -1, 0);
        sel = 0; pkt = '{1, 1, 1, 1, 1, 1, 1, 1};    run_packet(0, 0, -1, 0);
        sel = 0; pkt = '{0, 1, 1, 1, 1, 1, 1};       run_packet(0, 0, -1, 0);
        sel = 0; pkt = '{0, 0, 0, 0, 0, 0, 0, 1};    run_packet(0, 0, -1, 0);
        sel = 0; pkt = '{1, 1, 1, 1, 1, 1, 1};       run_packet(0, 0, 4, 3);

        // Partial packet with an underrun and a toggled level, then async reset.
        sel = 0; pkt = '{0, 1, 1, 1}; idx = 0; obs_d.delete(); obs_e.delete();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_out_valid", 32'(ov[0]), 32'(0));
        check_eq("async_rst_out_data", 32'(od[0]), 32'(1));
        check_eq("async_rst_out_eop", 32'(oe[0]), 32'(0));
        check_eq("async_rst_underrun", 32'(ur[0]), 32'(0));
        check_eq("async_rst_in_ready", 32'(rdy[0]), 32'(1));
        @(posedge clk12);
        #1 rst_n = 1'b1;
        pending = 1'b0; exp_valid = 1'b0; idx = 0; run_m = 0;
        under_m = '{1'b0, 1'b0, 1'b0};
        pkt = '{1, 1, 1, 1, 1, 1, 1};                run_packet(0, 0, -1, 0);

        sel = 2; pkt = '{1, 1, 1, 1};                run_packet(0, 0, -1, 0);

        for (int p = 0; p < 60; p++) begin
            int len;
            sel = $urandom_range(2);
            len = $urandom_range(24, 1);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back($urandom_range(99) < 70);
            run_packet(10, 20, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
